quartic_host: RTL
=================

# quartic_host

Host-side sequencer for the double-precision quartic evaluator, which computes y = a·x⁴ + b·x³ + c·x² + d·x + e. The block buffers a stream of x operands and holds a coefficient set. It drives the evaluator's `invalid`/`outvalid` protocol one evaluation at a time and keeps the evaluator's inputs stable for the whole evaluation. It returns each result, or a timeout marker, on a ready/valid output stream.

## Interface
Parameters:
- `DEPTH`, 8: x FIFO depth in entries; must be a power of 2, at least 2.
- `TIMEOUT`, 255: maximum cycles spent in RUN before the evaluation is abandoned.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `coef_we`, in, 1: write strobe for a shadow coefficient register.
- `coef_sel`, in, 3: selects the coefficient; 0=a, 1=b, 2=c, 3=d, 4=e; values 5–7 are ignored.
- `coef_data`, in, 64: IEEE-754 double written to the selected coefficient.
- `x_valid`, in, 1: x operand available.
- `x_data`, in, 64: x operand, IEEE-754 double.
- `x_ready`, out, 1: high when the FIFO is not full.
- `r_valid`, out, 1: result available.
- `r_data`, out, 64: evaluator result; 0 when the evaluation timed out.
- `r_timeout`, out, 1: qualifies `r_data`; high when the evaluation timed out.
- `r_ready`, in, 1: result consumer accepts the result.
- `ev_invalid`, out, 1: drives the evaluator's `invalid` input; high holds the evaluator in reset.
- `ev_x`, `ev_a`, `ev_b`, `ev_c`, `ev_d`, `ev_e`, out, 64 each: operands to the evaluator.
- `ev_res`, in, 64: evaluator result.
- `ev_outvalid`, in, 1: evaluator done; the evaluator holds it high until `ev_invalid` is raised again.
- `busy`, out, 1: high when the FSM is not in IDLE.
- `done_cnt`, out, 16: count of completed evaluations, including timeouts; wraps at 2¹⁶.

## Operation
- FSM states are IDLE, RUN and OUT.
- IDLE → RUN when the FIFO is not empty. On that edge:
  - pop the FIFO head into `ev_x`;
  - copy the shadow coefficients into `ev_a`..`ev_e`;
  - clear the timeout counter;
  - drive `ev_invalid` low.
- `ev_invalid` is low only in RUN and high in every other state. The evaluator therefore sees `invalid` high on the edge that starts RUN, which resets it cleanly.
- In RUN:
  - if `ev_outvalid` = 1: capture `ev_res` into `r_data`, set `r_timeout` = 0, go to OUT;
  - otherwise, when the counter reaches `TIMEOUT`: set `r_data` = 0, `r_timeout` = 1, go to OUT;
  - otherwise the counter increments.
  - `ev_outvalid` wins if it arrives in the same cycle as the timeout.
- In OUT, `r_valid` = 1. On `r_valid && r_ready`, `done_cnt` increments and the FSM goes to IDLE.
- `ev_x` and `ev_a`..`ev_e` change only on the IDLE → RUN edge, so they are stable for the whole evaluation.
- Coefficient writes always land in the shadow registers and are accepted in any state.
  - A write on the same edge as IDLE → RUN affects the next evaluation, not the current one.
- The FIFO accepts a push on `x_valid && x_ready`. A push and a pop on the same edge are both performed. Pointers wrap modulo `DEPTH`.

## Timing
- Reset values:
  - `ev_invalid` = 1, `x_ready` = 1;
  - `r_valid` = 0, `r_timeout` = 0, `busy` = 0, `done_cnt` = 0;
  - `r_data` = 0, `ev_x` = 0, `ev_a`..`ev_e` = 0, shadow coefficients = 0;
  - FIFO empty, FSM in IDLE.
- Reset mid-evaluation abandons the evaluation and discards FIFO contents. `ev_invalid` goes high immediately.
- A push into an empty FIFO while in IDLE reaches RUN on the next edge, so the minimum latency from x acceptance to RUN is 1 cycle.
- With evaluator latency L, defined as cycles from the start of RUN until `ev_outvalid` is seen, `r_valid` rises L+1 cycles after RUN is entered.
- Minimum gap between evaluations is 1 IDLE cycle after the OUT handshake.
- `x_ready` is registered-full based; it deasserts only when the FIFO holds `DEPTH` entries.

## Structure
- `quartic_pkg` contains:
  - the state enum (IDLE, RUN, OUT);
  - coefficient index constants `COEF_A`..`COEF_E`;
  - `FP64_ZERO`;
  - the `done_cnt` width.
- Sub-module `quartic_xfifo` is a synchronous 64-bit FIFO parameterised by `DEPTH`, with full/empty flags and push/pop.

## Test plan
Benches use a behavioural evaluator model with fixed latency L=20 unless stated. FP64 encodings: 1.0 = 0x3FF0000000000000, 2.0 = 0x4000000000000000.
- All coefficients = 1.0, push x = 1.0 → one result with `r_data` = 0x4014000000000000 (5.0), `r_timeout` = 0, `done_cnt` = 1.
- All coefficients = 1.0, push x = 2.0 → `r_data` = 0x403F000000000000 (31.0). Check that `ev_x`/`ev_a`..`ev_e` do not change during RUN and that `ev_invalid` is low for exactly the RUN cycles.
- Push 9 x values with `r_ready` = 0 and `DEPTH` = 8 → `x_ready` drops once 8 entries are buffered. Releasing `r_ready` returns all 9 results in push order.
- Write e = 2.0 during an evaluation → that result uses e = 1.0 (5.0); the next x = 1.0 yields 0x4018000000000000 (6.0).
- Model never raises `ev_outvalid` → `r_valid` appears after `TIMEOUT` cycles with `r_timeout` = 1 and `r_data` = 0; the next evaluation proceeds normally.
- Assert `rst` in mid-RUN with 3 entries queued → all outputs return to their reset values immediately, the FIFO is empty, and no result is produced.

Source files
------------

// File: rtl/quartic_pkg.sv
// rtl/quartic_pkg.sv - shared types and constants for the quartic evaluator host
package quartic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam logic [2:0] COEF_A = 3'd0;
  localparam logic [2:0] COEF_B = 3'd1;
  localparam logic [2:0] COEF_C = 3'd2;
  localparam logic [2:0] COEF_D = 3'd3;
  localparam logic [2:0] COEF_E = 3'd4;

  localparam logic [63:0] FP64_ZERO = 64'h0000_0000_0000_0000;

  localparam int DONE_W = 16;

endpackage

// File: rtl/quartic_xfifo.sv
// rtl/quartic_xfifo.sv - synchronous 64-bit x operand FIFO with full/empty flags
module quartic_xfifo #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [63:0] wdata,
  input  logic        pop,
  output logic [63:0] rdata,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset because empty guards every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/quartic_host.sv
// rtl/quartic_host.sv - sequencer feeding one x at a time to the quartic evaluator
module quartic_host
  import quartic_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coef_we,
  input  logic [2:0]        coef_sel,
  input  logic [63:0]       coef_data,
  input  logic              x_valid,
  input  logic [63:0]       x_data,
  output logic              x_ready,
  output logic              r_valid,
  output logic [63:0]       r_data,
  output logic              r_timeout,
  input  logic              r_ready,
  output logic              ev_invalid,
  output logic [63:0]       ev_x,
  output logic [63:0]       ev_a,
  output logic [63:0]       ev_b,
  output logic [63:0]       ev_c,
  output logic [63:0]       ev_d,
  output logic [63:0]       ev_e,
  input  logic [63:0]       ev_res,
  input  logic              ev_outvalid,
  output logic              busy,
  output logic [DONE_W-1:0] done_cnt
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  state_t        state;
  state_t        state_nxt;
  logic          start;
  logic          fifo_full;
  logic          fifo_empty;
  logic [63:0]   fifo_rdata;
  logic [TW-1:0] tcnt;
  logic [63:0]   sh_a;
  logic [63:0]   sh_b;
  logic [63:0]   sh_c;
  logic [63:0]   sh_d;
  logic [63:0]   sh_e;

  assign x_ready = !fifo_full;

  quartic_xfifo #(
    .DEPTH(DEPTH)
  ) u_xfifo (
    .clk  (clk),
    .rst  (rst),
    .push (x_valid),
    .wdata(x_data),
    .pop  (start),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // State register; reset lands in IDLE so ev_invalid rises at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs; ev_invalid is low only while running.
  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    ev_invalid = 1'b1;
    r_valid    = 1'b0;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (!fifo_empty) begin
          start     = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        ev_invalid = 1'b0;
        if (ev_outvalid || (tcnt == TMAX)) begin
          state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        r_valid = 1'b1;
        if (r_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Shadow coefficients accept writes in any state; unused selects are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a <= FP64_ZERO;
      sh_b <= FP64_ZERO;
      sh_c <= FP64_ZERO;
      sh_d <= FP64_ZERO;
      sh_e <= FP64_ZERO;
    end else if (coef_we) begin
      case (coef_sel)
        COEF_A:  sh_a <= coef_data;
        COEF_B:  sh_b <= coef_data;
        COEF_C:  sh_c <= coef_data;
        COEF_D:  sh_d <= coef_data;
        COEF_E:  sh_e <= coef_data;
        default: ;
      endcase
    end
  end

  // Operand latch: evaluator inputs change only when an evaluation starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_x <= FP64_ZERO;
      ev_a <= FP64_ZERO;
      ev_b <= FP64_ZERO;
      ev_c <= FP64_ZERO;
      ev_d <= FP64_ZERO;
      ev_e <= FP64_ZERO;
    end else if (start) begin
      ev_x <= fifo_rdata;
      ev_a <= sh_a;
      ev_b <= sh_b;
      ev_c <= sh_c;
      ev_d <= sh_d;
      ev_e <= sh_e;
    end
  end

  // Timeout counter, result capture and completion count; outvalid beats timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt      <= '0;
      r_data    <= FP64_ZERO;
      r_timeout <= 1'b0;
      done_cnt  <= '0;
    end else begin
      if (start) begin
        tcnt <= '0;
      end else if (state == ST_RUN) begin
        if (ev_outvalid) begin
          r_data    <= ev_res;
          r_timeout <= 1'b0;
        end else if (tcnt == TMAX) begin
          r_data    <= FP64_ZERO;
          r_timeout <= 1'b1;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
      if ((state == ST_OUT) && r_ready) begin
        done_cnt <= done_cnt + 1'b1;
      end
    end
  end

endmodule
